// File: rtl/debounce_bcd_counter_pkg.sv
// Shared types and constants for the debounced up/down BCD event counter.
package debounce_bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

endpackage

// File: rtl/debounce_bcd_counter_debounce_ch.sv
// One switch channel: two-flop synchroniser, tick-sampled stability counter,
// registered debounced level and rising-edge pulse.
module debounce_ch #(
  parameter int STABLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw,
  output logic sw_db,
  output logic sw_rise
);

  localparam int SW = $clog2(STABLE + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE - 1);

  logic          sync1;
  logic          sync2;
  logic [SW-1:0] stab;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stab    <= '0;
      sw_db   <= 1'b0;
      sw_rise <= 1'b0;
    end else begin
      sync1   <= sw;
      sync2   <= sync1;
      sw_rise <= 1'b0;
      if (tick) begin
        // Any tick that agrees with the current level restarts the run.
        if (sync2 == sw_db) begin
          stab <= '0;
        end else if (stab == STAB_LAST) begin
          sw_db   <= sync2;
          sw_rise <= sync2;
          stab    <= '0;
        end else begin
          stab <= stab + SW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/debounce_bcd_counter.sv
// N-channel switch debouncer feeding a multi-digit up/down BCD counter:
// channel 0 rising edges count up, channel 1 rising edges count down.
module debounce_bcd_counter
  import debounce_bcd_counter_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int DIV_W  = 16,
  parameter int STABLE = 4,
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       sw,
  output logic [N_CH-1:0]       sw_db,
  output logic [N_CH-1:0]       sw_rise,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  wrap
);

  logic [DIV_W-1:0]    div;
  logic                tick;
  logic                up;
  logic                dn;
  logic                chain;
  logic [4*DIGITS-1:0] bcd_next;
  logic                wrap_next;

  always_ff @(posedge clk) begin
    if (rst) div <= '0;
    else     div <= div + DIV_W'(1);
  end

  assign tick = &div;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(.STABLE(STABLE)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .sw      (sw[i]),
      .sw_db   (sw_db[i]),
      .sw_rise (sw_rise[i])
    );
  end

  assign up = sw_rise[0];
  assign dn = sw_rise[1];

  // chain carries the ripple (carry on up, borrow on down); if it survives
  // past the top digit the whole counter wrapped.
  always_comb begin
    bcd_next = bcd;
    chain    = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (up && !dn && chain) begin
        if (bcd[4*d +: 4] == BCD_MAX) begin
          bcd_next[4*d +: 4] = BCD_ZERO;
        end else begin
          bcd_next[4*d +: 4] = bcd[4*d +: 4] + 4'd1;
          chain              = 1'b0;
        end
      end else if (dn && !up && chain) begin
        if (bcd[4*d +: 4] == BCD_ZERO) begin
          bcd_next[4*d +: 4] = BCD_MAX;
        end else begin
          bcd_next[4*d +: 4] = bcd[4*d +: 4] - 4'd1;
          chain              = 1'b0;
        end
      end
    end
    wrap_next = (up ^ dn) & chain;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd  <= '0;
      wrap <= 1'b0;
    end else begin
      bcd  <= bcd_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_debounce_bcd_counter.sv
// Directed-plus-random bench for debounce_bcd_counter with a cycle-level
// reference model built from the counting and acceptance rules.
module tb_debounce_bcd_counter;

  localparam int N_CH   = 3;
  localparam int DIV_W  = 2;
  localparam int STABLE = 3;
  localparam int DIGITS = 2;
  localparam int TICK_P = 1 << DIV_W;
  localparam int MODV   = 100;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_CH-1:0]     sw  = '0;
  logic [N_CH-1:0]     sw_db;
  logic [N_CH-1:0]     sw_rise;
  logic [4*DIGITS-1:0] bcd;
  logic                wrap;

  debounce_bcd_counter #(
    .N_CH(N_CH), .DIV_W(DIV_W), .STABLE(STABLE), .DIGITS(DIGITS)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .sw_db(sw_db), .sw_rise(sw_rise), .bcd(bcd), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int              m_cnt;
  bit              m_wrap;
  bit [N_CH-1:0]   m_db;
  bit [N_CH-1:0]   m_rise;
  int              m_run[N_CH];
  int              m_e;
  logic [N_CH-1:0] m_q[$];

  // DUT event tallies
  int g_rise[N_CH];
  int g_wrap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_bcd(input int c);
    return {4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_edge(input logic [N_CH-1:0] s, input logic r);
    bit tick_now, up, dn;
    logic [N_CH-1:0] smp;
    if (r) begin
      m_e = 0; m_q.delete(); m_q.push_back('0); m_q.push_back('0);
      m_db = '0; m_rise = '0; m_cnt = 0; m_wrap = 1'b0;
      for (int i = 0; i < N_CH; i++) m_run[i] = 0;
    end else begin
      up = m_rise[0]; dn = m_rise[1];
      m_wrap = 1'b0;
      if (up && !dn) begin
        m_wrap = (m_cnt == MODV - 1);
        m_cnt  = (m_cnt + 1) % MODV;
      end else if (dn && !up) begin
        m_wrap = (m_cnt == 0);
        m_cnt  = (m_cnt + MODV - 1) % MODV;
      end
      tick_now = ((m_e % TICK_P) == TICK_P - 1);
      m_e++;
      smp = m_q.pop_front();
      m_q.push_back(s);
      m_rise = '0;
      if (tick_now) begin
        for (int i = 0; i < N_CH; i++) begin
          if (smp[i] == m_db[i]) m_run[i] = 0;
          else if (m_run[i] + 1 == STABLE) begin
            m_db[i] = smp[i]; m_rise[i] = smp[i]; m_run[i] = 0;
          end else m_run[i]++;
        end
      end
    end
  endtask

  task automatic step();
    logic [N_CH-1:0] s;
    logic r;
    s = sw; r = rst;
    @(posedge clk);
    model_edge(s, r);
    #1;
    for (int i = 0; i < N_CH; i++) g_rise[i] += int'(sw_rise[i]);
    g_wrap += int'(wrap);
    check("sw_db", 32'(sw_db), 32'(m_db));
    check("sw_rise", 32'(sw_rise), 32'(m_rise));
    check("bcd", 32'(bcd), 32'(exp_bcd(m_cnt)));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    check("rst_outputs", {sw_db, sw_rise, bcd, wrap}, '0);
    rst = 1'b0;
  endtask

  // One press/release on a channel with random contact bounce at both ends.
  task automatic press(input int ch);
    int w;
    repeat ($urandom_range(0, 5)) begin sw[ch] = 1'($urandom_range(0, 1)); step(); end
    sw[ch] = 1'b1;
    w = 0;
    while (!m_db[ch] && w < 60) begin step(); w++; end
    check("press_accept", 32'(m_db[ch]), 32'd1);
    repeat (2) step();
    repeat ($urandom_range(0, 5)) begin sw[ch] = 1'($urandom_range(0, 1)); step(); end
    sw[ch] = 1'b0;
    w = 0;
    while (m_db[ch] && w < 60) begin step(); w++; end
    check("release_accept", 32'(m_db[ch]), 32'd0);
  endtask

  initial begin
    int lat, r0, r1, w0;
    for (int i = 0; i < N_CH; i++) g_rise[i] = 0;
    g_wrap = 0;
    m_q.push_back('0); m_q.push_back('0);

    rst = 1'b1;
    step();
    do_reset();

    // clean press
    r0 = g_rise[0];
    sw[0] = 1'b1;
    lat = 0;
    while (!sw_db[0] && lat < 30) begin step(); lat++; end
    check("clean_latency", 32'(lat >= 11 && lat <= 2 + STABLE * TICK_P), 32'd1);
    step();
    check("clean_bcd", 32'(bcd), 32'h01);
    check("clean_one_rise", 32'(g_rise[0] - r0), 32'd1);
    sw[0] = 1'b0;
    lat = 0;
    while (m_db[0] && lat < 30) begin step(); lat++; end

    // bounce that never settles
    r0 = g_rise[0];
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) sw[0] = ~sw[0];
      step();
    end
    sw[0] = 1'b0;
    repeat (20) step();
    check("bounce_db", 32'(sw_db[0]), 32'd0);
    check("bounce_rise", 32'(g_rise[0] - r0), 32'd0);
    check("bounce_bcd", 32'(bcd), 32'h01);

    // down wrap then up wrap back
    do_reset();
    w0 = g_wrap;
    press(1);
    check("dn_wrap_bcd", 32'(bcd), 32'h99);
    check("dn_wrap_pulse", 32'(g_wrap - w0), 32'd1);
    w0 = g_wrap;
    press(0);
    check("up_from_99_bcd", 32'(bcd), 32'h00);
    check("up_from_99_pulse", 32'(g_wrap - w0), 32'd1);

    // 99 presses then wrap
    do_reset();
    w0 = g_wrap;
    for (int k = 0; k < 99; k++) press(0);
    check("up99_bcd", 32'(bcd), 32'h99);
    check("up99_no_wrap", 32'(g_wrap - w0), 32'd0);
    press(0);
    check("up100_bcd", 32'(bcd), 32'h00);
    check("up100_wrap_once", 32'(g_wrap - w0), 32'd1);

    // simultaneous up/down, then debounce-only channel
    do_reset();
    r0 = g_rise[0]; r1 = g_rise[1]; w0 = g_wrap;
    sw[0] = 1'b1; sw[1] = 1'b1;
    lat = 0;
    while (!(sw_db[0] && sw_db[1]) && lat < 30) begin step(); lat++; end
    repeat (2) step();
    check("simul_rises", 32'((g_rise[0] - r0) + (g_rise[1] - r1)), 32'd2);
    check("simul_bcd", 32'(bcd), 32'h00);
    check("simul_wrap", 32'(g_wrap - w0), 32'd0);
    sw[0] = 1'b0; sw[1] = 1'b0;
    lat = 0;
    while ((m_db[0] || m_db[1]) && lat < 30) begin step(); lat++; end
    sw[2] = 1'b1;
    lat = 0;
    while (!sw_db[2] && lat < 30) begin step(); lat++; end
    step();
    check("ch2_db", 32'(sw_db[2]), 32'd1);
    check("ch2_bcd", 32'(bcd), 32'h00);
    sw[2] = 1'b0;
    lat = 0;
    while (m_db[2] && lat < 30) begin step(); lat++; end

    // reset in the middle of a stability run
    do_reset();
    for (int k = 0; k < 37; k++) press(0);
    check("pre_reset_bcd", 32'(bcd), 32'h37);
    sw[1] = 1'b1;
    lat = 0;
    while (m_run[1] != 2 && lat < 30) begin step(); lat++; end
    check("mid_run_reached", 32'(m_run[1]), 32'd2);
    do_reset();
    lat = 0;
    while (!sw_db[1] && lat < 40) begin step(); lat++; end
    check("fresh_run_latency", 32'(lat), 32'(STABLE * TICK_P));
    step();
    check("post_reset_dn_bcd", 32'(bcd), 32'h99);
    sw[1] = 1'b0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
